// File: rtl/pe_mode_acc.sv
// pe_mode_acc: multi-lane MAC processing element (CV/DW/PW/GAP) with per-group psum accumulation.
// Optional build macro ACC_SAT_EN: saturating accumulation with a sticky per-group overflow hold.

module pe_mode_acc_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     accept_i,
  input  logic [1:0]               mode_i,
  input  logic signed [DATA_W-1:0] pix_i,
  input  logic signed [DATA_W-1:0] cast_i,
  input  logic signed [DATA_W-1:0] chain_i,
  input  logic signed [DATA_W-1:0] weight_i,
  input  logic                     prod_vld_i,
  input  logic                     prod_first_i,
  output logic [DATA_W-1:0]        np_o,
  output logic [ACC_W-1:0]         acc_o
);
  localparam int         PW_W  = 2 * DATA_W;
  localparam logic [1:0] M_CV  = 2'd0;
  localparam logic [1:0] M_DW  = 2'd1;
  localparam logic [1:0] M_GAP = 2'd3;

  logic signed [DATA_W-1:0] sel;
  logic signed [PW_W-1:0]   sel_x, w_x, prod_d, prod_q;
  logic        [DATA_W-1:0] np_q;
  logic signed [ACC_W-1:0]  acc_d, acc_q, acc_base, prod_ext;

  // CV chains through the neighbour's registered pixel; chain_i of lane 0 is pixel_cast.
  always_comb begin
    sel = pix_i;
    case (mode_i)
      M_CV:    sel = chain_i;
      M_DW:    sel = cast_i;
      default: sel = pix_i;
    endcase
    sel_x  = PW_W'(sel);
    w_x    = PW_W'(weight_i);
    prod_d = (mode_i == M_GAP) ? sel_x : sel_x * w_x;
  end

  assign prod_ext = ACC_W'(prod_q);
  assign acc_base = prod_first_i ? '0 : acc_q;

`ifdef ACC_SAT_EN
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_x;
  logic                  ovf, sat_d, sat_q;

  // Once a lane clamps, it holds the clamp value until the next group's first beat.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    sum_x = SUM_W'(acc_base) + SUM_W'(prod_ext);
    ovf   = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    if (prod_vld_i && (prod_first_i || !sat_q)) begin
      sat_d = ovf;
      if (ovf) acc_d = sum_x[ACC_W] ? ACC_MIN : ACC_MAX;
      else     acc_d = sum_x[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end
`else
  always_comb begin
    acc_d = acc_q;
    if (prod_vld_i) acc_d = acc_base + prod_ext;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      np_q   <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (accept_i) begin
        np_q   <= sel;
        prod_q <= prod_d;
      end
      acc_q <= acc_d;
    end
  end

  assign np_o  = np_q;
  assign acc_o = acc_q;
endmodule

module pe_mode_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int LANES  = 4,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [LEN_W-1:0]        acc_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] pixel,
  input  logic [DATA_W-1:0]       pixel_cast,
  input  logic [LANES*DATA_W-1:0] weight,
  output logic [LANES*DATA_W-1:0] next_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  psum,
  output logic                    busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d, mode_eff;
  logic [LEN_W-1:0] len_q, len_d, len_in, cnt_q, cnt_d;
  logic             accept, first_beat, prod_vld_q, prod_first_q;

  logic [LANES-1:0][DATA_W-1:0] pix_l, w_l, np_l, chain_l;
  logic [LANES-1:0][ACC_W-1:0]  acc_l;

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_ACC);
  assign out_valid  = (state_q == S_HOLD);
  assign busy       = (state_q != S_IDLE);
  assign accept     = in_valid && in_ready;
  assign first_beat = accept && (state_q == S_IDLE);
  assign len_in     = (acc_len == '0) ? LEN_W'(1) : acc_len;
  // The first beat must already use the incoming mode, before it is latched.
  assign mode_eff   = first_beat ? mode : mode_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        mode_d  = mode;
        len_d   = len_in;
        cnt_d   = LEN_W'(1);
        state_d = (len_in == LEN_W'(1)) ? S_DRAIN : S_ACC;
      end
      S_ACC: if (accept) begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      prod_vld_q   <= accept;
      prod_first_q <= first_beat;
    end
  end

  assign pix_l = pixel;
  assign w_l   = weight;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_head
        assign chain_l[gi] = pixel_cast;
      end else begin : g_tail
        assign chain_l[gi] = np_l[gi-1];
      end

      pe_mode_acc_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
        .clk          (clk),
        .rst          (rst),
        .accept_i     (accept),
        .mode_i       (mode_eff),
        .pix_i        (pix_l[gi]),
        .cast_i       (pixel_cast),
        .chain_i      (chain_l[gi]),
        .weight_i     (w_l[gi]),
        .prod_vld_i   (prod_vld_q),
        .prod_first_i (prod_first_q),
        .np_o         (np_l[gi]),
        .acc_o        (acc_l[gi])
      );
    end
  endgenerate

  assign next_pixel = np_l;
  assign psum       = acc_l;
endmodule
